sram_io_ctrl: RTL and testbench

SRAM_IO_CTRL -- requirements
Module: sram_io_ctrl

---
 rtl/sram_defs_pkg.sv | 24 ++
 rtl/sram_io_pads.sv | 32 +++
 rtl/sram_io_ctrl.sv | 160 ++++++++++++++++
 tb/tb_sram_io_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_defs_pkg.sv
// Shared definitions for the SRAM I/O controller family.
// Holds the access state encoding and the wait-counter width so that
// sram_io_ctrl and sram_tester agree on both.
package sram_defs;

  localparam int WAIT_BITS = 3;

  typedef logic [WAIT_BITS-1:0] wait_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WR_SETUP  = 3'd1,
    WR_PULSE  = 3'd2,
    WR_HOLD   = 3'd3,
    RD_ACCESS = 3'd4,
    RD_DONE   = 3'd5
  } state_t;

  // True for every state in which the controller owns the data bus.
  function automatic logic is_write_state(input state_t s);
    return (s == WR_SETUP) || (s == WR_PULSE) || (s == WR_HOLD);
  endfunction

endpackage

// File: rtl/sram_io_pads.sv
// Tristate pad cell for the SRAM data bus.
// Output enable and output data are registered so the pins change only on
// clock edges; the input path is a plain wire back to the controller.
module sram_io_pads #(
  parameter int DATA_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 drive_d,
  input  logic [DATA_BITS-1:0] data_d,
  output logic [DATA_BITS-1:0] data_in,
  inout  wire  [DATA_BITS-1:0] pad
);

  logic                 drive_q;
  logic [DATA_BITS-1:0] data_q;

  // Register the enable and outgoing data; reset releases the bus at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drive_q <= 1'b0;
      data_q  <= '0;
    end else begin
      drive_q <= drive_d;
      data_q  <= data_d;
    end
  end

  assign pad     = drive_q ? data_q : {DATA_BITS{1'bz}};
  assign data_in = pad;

endmodule

// File: rtl/sram_io_ctrl.sv
// Asynchronous SRAM access controller: one request at a time, split into
// setup / strobe / hold phases with WAIT_CYCLES extra strobe cycles.
// Optional feature macro: SRAM_IO_CTRL_LAST_EN adds last_rd_addr and
// last_wr_data debug outputs.
module sram_io_ctrl
  import sram_defs::*;
#(
  parameter int ADDR_BITS   = 20,
  parameter int DATA_BITS   = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [DATA_BITS-1:0] req_wdata,
  output logic                 rd_valid,
  output logic [DATA_BITS-1:0] rd_data,
  output logic [ADDR_BITS-1:0] sram_io_addr_bus,
  inout  wire  [DATA_BITS-1:0] sram_io_data_bus,
  output logic                 sram_io_ce_n,
  output logic                 sram_io_we_n,
  output logic                 sram_io_oe_n
`ifdef SRAM_IO_CTRL_LAST_EN
  ,
  output logic [ADDR_BITS-1:0] last_rd_addr,
  output logic [DATA_BITS-1:0] last_wr_data
`endif
);

  localparam wait_t WAIT_INIT = wait_t'(WAIT_CYCLES);

  state_t               state_q, state_d;
  wait_t                wait_q, wait_d;
  logic [ADDR_BITS-1:0] addr_q;
  logic [DATA_BITS-1:0] wdata_q;
  logic [DATA_BITS-1:0] rd_data_q;
  logic [DATA_BITS-1:0] pad_in;
  logic                 accept;
  logic                 pad_drive_d;
  logic [DATA_BITS-1:0] pad_data_d;

  assign accept = req_valid && req_ready;

  // Next-state and strobe decode; the counter only counts in strobe states.
  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    req_ready    = 1'b0;
    rd_valid     = 1'b0;
    sram_io_ce_n = 1'b1;
    sram_io_we_n = 1'b1;
    sram_io_oe_n = 1'b1;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (accept) begin
          if (req_write) begin
            state_d = WR_SETUP;
          end else begin
            state_d = RD_ACCESS;
            wait_d  = WAIT_INIT;
          end
        end
      end
      WR_SETUP: begin
        sram_io_ce_n = 1'b0;
        state_d      = WR_PULSE;
        wait_d       = WAIT_INIT;
      end
      WR_PULSE: begin
        sram_io_ce_n = 1'b0;
        sram_io_we_n = 1'b0;
        if (wait_q == '0) state_d = WR_HOLD;
        else              wait_d  = wait_q - 1'b1;
      end
      WR_HOLD: begin
        sram_io_ce_n = 1'b0;
        state_d      = IDLE;
      end
      RD_ACCESS: begin
        sram_io_ce_n = 1'b0;
        sram_io_oe_n = 1'b0;
        if (wait_q == '0) state_d = RD_DONE;
        else              wait_d  = wait_q - 1'b1;
      end
      RD_DONE: begin
        rd_valid = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
        wait_d  = '0;
      end
    endcase
  end

  // Pad registers are fed from the next state so the bus is driven exactly
  // during the write states and already released when a read starts.
  always_comb begin
    pad_drive_d = is_write_state(state_d);
    pad_data_d  = accept ? req_wdata : wdata_q;
  end

  // State, wait counter and request capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      wait_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  // Read data is sampled from the bus on the edge that enters RD_DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_q <= '0;
    end else if (state_q == RD_ACCESS && wait_q == '0) begin
      rd_data_q <= pad_in;
    end
  end

  assign rd_data          = rd_data_q;
  assign sram_io_addr_bus = addr_q;

  sram_io_pads #(
    .DATA_BITS(DATA_BITS)
  ) u_pads (
    .clk    (clk),
    .reset_n(reset_n),
    .drive_d(pad_drive_d),
    .data_d (pad_data_d),
    .data_in(pad_in),
    .pad    (sram_io_data_bus)
  );

`ifdef SRAM_IO_CTRL_LAST_EN
  // Debug copies of the most recent read address and write data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_rd_addr <= '0;
      last_wr_data <= '0;
    end else begin
      if (state_q == RD_DONE) last_rd_addr <= addr_q;
      if (state_q == WR_HOLD) last_wr_data <= wdata_q;
    end
  end
`endif

endmodule

// File: tb/tb_sram_io_ctrl.sv
// Self-checking bench for sram_io_ctrl: instance 0 uses WAIT_CYCLES=0,
// instance 1 uses WAIT_CYCLES=3, each with its own behavioural SRAM.
// Optional feature macro: SRAM_IO_CTRL_LAST_EN enables the debug-port checks.
module tb_sram_io_ctrl;

  localparam int AW = 20;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic [1:0]    req_valid;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;

  wire  [1:0]    req_ready, rd_valid, ce_n, we_n, oe_n, drv;
  wire  [DW-1:0] rd_data  [2];
  wire  [AW-1:0] addr_bus [2];
  wire  [DW-1:0] bus_view [2];
`ifdef SRAM_IO_CTRL_LAST_EN
  wire  [AW-1:0] last_rd_addr [2];
  wire  [DW-1:0] last_wr_data [2];
`endif

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 2; g++) begin : gen
    wire  [DW-1:0] dbus;
    logic [DW-1:0] mem [0:255];
    int            viol = 0;

    sram_io_ctrl #(
      .ADDR_BITS  (AW),
      .DATA_BITS  (DW),
      .WAIT_CYCLES(g == 0 ? 0 : 3)
    ) u_dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .req_valid       (req_valid[g]),
      .req_ready       (req_ready[g]),
      .req_write       (req_write),
      .req_addr        (req_addr),
      .req_wdata       (req_wdata),
      .rd_valid        (rd_valid[g]),
      .rd_data         (rd_data[g]),
      .sram_io_addr_bus(addr_bus[g]),
      .sram_io_data_bus(dbus),
      .sram_io_ce_n    (ce_n[g]),
      .sram_io_we_n    (we_n[g]),
      .sram_io_oe_n    (oe_n[g])
`ifdef SRAM_IO_CTRL_LAST_EN
      ,
      .last_rd_addr    (last_rd_addr[g]),
      .last_wr_data    (last_wr_data[g])
`endif
    );

    // Behavioural SRAM: drives the bus on a read strobe, stores on write strobe.
    assign dbus = (!ce_n[g] && !oe_n[g] && we_n[g]) ? mem[addr_bus[g][7:0]] : {DW{1'bz}};
    assign bus_view[g] = dbus;
    assign drv[g] = u_dut.u_pads.drive_q;

    always @(posedge clk) begin
      if (!ce_n[g] && !we_n[g]) mem[addr_bus[g][7:0]] <= dbus;
    end

    // Sticky count of strobe overlap or bus contention with the SRAM.
    always @(negedge clk) begin
      if ((!we_n[g] && !oe_n[g]) || (drv[g] && !oe_n[g])) viol <= viol + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One complete access on instance u, returning what was observed per cycle.
  task automatic applyStimulus(input int u, input logic wr, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, output int ready_low,
                               output int strobe_low, output int bus_cyc, output int addr_cyc,
                               output int rdv_cnt, output int rdv_at, output logic [DW-1:0] rdat);
    ready_low = 0; strobe_low = 0; bus_cyc = 0; addr_cyc = 0;
    rdv_cnt = 0; rdv_at = -1; rdat = '0;
    @(negedge clk);
    req_write = wr; req_addr = a; req_wdata = d; req_valid[u] = 1'b1;
    @(posedge clk);
    #1 req_valid[u] = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (req_ready[u]) break;
      ready_low++;
      if (wr ? !we_n[u] : !oe_n[u]) strobe_low++;
      if (drv[u] && bus_view[u] == d) bus_cyc++;
      if (addr_bus[u] == a) addr_cyc++;
      if (rd_valid[u]) begin
        rdv_cnt++;
        rdv_at = c;
        rdat   = rd_data[u];
      end
    end
  endtask

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            exp_ready_low;
    int            exp_bus;
    logic [DW-1:0] exp_rd;
  } vec_t;

  vec_t vecs [6];

  initial begin : main
    int            rl, sl, bc, ac, rc, ra;
    logic [DW-1:0] rdat;
    int            acc_cyc [8];
    logic [DW-1:0] got [4];
    int            idx, ngot;
    logic          rdy;

    vecs[0] = '{1'b1, 20'h00012, 16'hA5C3, 3, 3, 16'h0000};
    vecs[1] = '{1'b0, 20'h00012, 16'h0000, 2, 0, 16'hA5C3};
    vecs[2] = '{1'b1, 20'h00034, 16'h1234, 3, 3, 16'hA5C3};
    vecs[3] = '{1'b1, 20'h0FFFF, 16'h5A5A, 3, 3, 16'hA5C3};
    vecs[4] = '{1'b0, 20'h00034, 16'h0000, 2, 0, 16'h1234};
    vecs[5] = '{1'b0, 20'h0FFFF, 16'h0000, 2, 0, 16'h5A5A};

    reset_n = 1'b0; req_valid = 2'b00; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    req_write = 1'b1; req_addr = 20'h00077; req_valid = 2'b11;
    repeat (2) @(negedge clk);
    checkOutput("reset_ready", {30'd0, req_ready}, 32'h3);
    checkOutput("reset_ce_n", {30'd0, ce_n}, 32'h3);
    checkOutput("reset_we_n", {30'd0, we_n}, 32'h3);
    checkOutput("reset_oe_n", {30'd0, oe_n}, 32'h3);
    checkOutput("reset_bus_drive", {30'd0, drv}, 32'h0);
    checkOutput("reset_rd_valid", {30'd0, rd_valid}, 32'h0);
    checkOutput("reset_rd_data0", rd_data[0], 32'h0);
    checkOutput("reset_rd_data1", rd_data[1], 32'h0);
    checkOutput("reset_addr0", addr_bus[0], 32'h0);
    checkOutput("reset_addr1", addr_bus[1], 32'h0);
    req_valid = 2'b00;
    reset_n = 1'b1;
    @(negedge clk);

    // Table-driven single accesses on the WAIT_CYCLES=0 instance.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, rl, sl, bc, ac, rc, ra, rdat);
      checkOutput($sformatf("v%0d_ready_low", i), rl, vecs[i].exp_ready_low);
      checkOutput($sformatf("v%0d_strobe_low", i), sl, 1);
      checkOutput($sformatf("v%0d_bus_cycles", i), bc, vecs[i].exp_bus);
      checkOutput($sformatf("v%0d_addr_cycles", i), ac, vecs[i].exp_ready_low);
      checkOutput($sformatf("v%0d_rd_valid_count", i), rc, vecs[i].wr ? 0 : 1);
      if (!vecs[i].wr) begin
        checkOutput($sformatf("v%0d_rd_valid_at", i), ra, 2);
        checkOutput($sformatf("v%0d_read_data", i), rdat, vecs[i].exp_rd);
      end
      checkOutput($sformatf("v%0d_rd_data_held", i), rd_data[0], vecs[i].exp_rd);
      checkOutput($sformatf("v%0d_addr_retained", i), addr_bus[0], vecs[i].addr);
    end

    // WAIT_CYCLES=3 instance: stretched strobes at the top address.
    applyStimulus(1, 1'b1, 20'hFFFFF, 16'h0001, rl, sl, bc, ac, rc, ra, rdat);
    checkOutput("w3_wr_ready_low", rl, 6);
    checkOutput("w3_we_low", sl, 4);
    checkOutput("w3_wr_bus_cycles", bc, 6);
    applyStimulus(1, 1'b0, 20'hFFFFF, 16'h0000, rl, sl, bc, ac, rc, ra, rdat);
    checkOutput("w3_rd_ready_low", rl, 5);
    checkOutput("w3_oe_low", sl, 4);
    checkOutput("w3_rd_valid_count", rc, 1);
    checkOutput("w3_rd_valid_at", ra, 5);
    checkOutput("w3_read_data", rdat, 16'h0001);

    // Back-to-back stream with req_valid held: W k, R k for k = 0..3.
    idx = 0; ngot = 0;
    @(negedge clk);
    req_write = 1'b1; req_addr = 20'h00040; req_wdata = 16'h3C00; req_valid[0] = 1'b1;
    for (int cyc = 0; cyc < 120; cyc++) begin
      if (rd_valid[0] && ngot < 4) begin
        got[ngot] = rd_data[0];
        ngot++;
      end
      if (idx == 8 && ngot == 4) break;
      rdy = req_ready[0];
      @(posedge clk);
      if (rdy && req_valid[0]) begin
        acc_cyc[idx] = cyc;
        idx++;
        #1;
        if (idx < 8) begin
          req_write = (idx % 2 == 0);
          req_addr  = 20'h00040 + AW'(idx / 2);
          req_wdata = 16'h3C00 + DW'(idx / 2);
        end else begin
          req_valid[0] = 1'b0;
        end
      end
      @(negedge clk);
    end
    req_valid[0] = 1'b0;
    checkOutput("stream_accepted", idx, 8);
    checkOutput("stream_reads", ngot, 4);
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("stream_data%0d", k), (k < ngot) ? got[k] : 16'hxxxx, 16'h3C00 + k);
    for (int i = 0; i < 7; i++)
      if (i + 1 < idx)
        checkOutput($sformatf("stream_gap%0d", i), acc_cyc[i+1] - acc_cyc[i], (i % 2 == 0) ? 4 : 3);

`ifdef SRAM_IO_CTRL_LAST_EN
    applyStimulus(0, 1'b1, 20'h00ABC, 16'h1234, rl, sl, bc, ac, rc, ra, rdat);
    applyStimulus(0, 1'b0, 20'h00ABC, 16'h0000, rl, sl, bc, ac, rc, ra, rdat);
    checkOutput("last_wr_data", last_wr_data[0], 16'h1234);
    checkOutput("last_rd_addr", last_rd_addr[0], 20'h00ABC);
`endif

    // Reset during WR_PULSE must release we_n and the bus immediately.
    @(negedge clk);
    req_write = 1'b1; req_addr = 20'h00050; req_wdata = 16'hBEEF; req_valid[0] = 1'b1;
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("abort_we_low_before", we_n[0], 1'b0);
    reset_n = 1'b0;
    #1;
    checkOutput("abort_we_n", we_n[0], 1'b1);
    checkOutput("abort_ce_n", ce_n[0], 1'b1);
    checkOutput("abort_bus_released", drv[0], 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // Reset during RD_ACCESS must suppress the rd_valid pulse.
    @(negedge clk);
    req_write = 1'b0; req_addr = 20'h00034; req_valid[0] = 1'b1;
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("abort_oe_n", oe_n[0], 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    rc = 0;
    repeat (5) begin
      @(negedge clk);
      if (rd_valid[0]) rc++;
    end
    checkOutput("abort_no_rd_valid", rc, 0);
    checkOutput("abort_rd_data_cleared", rd_data[0], 16'h0000);

    applyStimulus(0, 1'b0, 20'h00034, 16'h0000, rl, sl, bc, ac, rc, ra, rdat);
    checkOutput("post_reset_ready_low", rl, 2);
    checkOutput("post_reset_read", rdat, 16'h1234);

    checkOutput("no_overlap_inst0", gen[0].viol, 0);
    checkOutput("no_overlap_inst1", gen[1].viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

endmodule
